// File: rtl/cmp_stats_pkg.sv
// rtl/cmp_stats_pkg.sv - shared types, encodings and helpers for cmp_stats
package cmp_stats_pkg;

  // Widest count the majority helper handles; WINDOW tops out at 255
  localparam int STAT_W = 8;

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_REPORT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    MAJ_NONE = 2'b00,
    MAJ_GT   = 2'b01,
    MAJ_EQ   = 2'b10,
    MAJ_LT   = 2'b11
  } maj_e;

  // A comparator result is legal only when exactly one of {gt,eq,lt} is set
  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  // Largest category wins; ties go eq, then gt, then lt; all zero means no verdict
  function automatic maj_e pick_major(input logic [STAT_W-1:0] g,
                                      input logic [STAT_W-1:0] e,
                                      input logic [STAT_W-1:0] l);
    if (g == '0 && e == '0 && l == '0) return MAJ_NONE;
    else if (e >= g && e >= l)         return MAJ_EQ;
    else if (g >= l)                   return MAJ_GT;
    else                               return MAJ_LT;
  endfunction

endpackage

// File: rtl/cmp_stats_if.sv
// rtl/cmp_stats_if.sv - sample input and summary output bundle for cmp_stats
interface cmp_stats_if #(
  parameter int WINDOW = 16
);
  import cmp_stats_pkg::*;

  localparam int CW = $clog2(WINDOW + 1);

  logic          in_valid;
  logic          in_ready;
  logic          gt;
  logic          eq;
  logic          lt;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] gt_cnt;
  logic [CW-1:0] eq_cnt;
  logic [CW-1:0] lt_cnt;
  logic [CW-1:0] err_cnt;
  maj_e          major;

  // Producer of samples and consumer of summaries
  modport master (
    output in_valid, gt, eq, lt, out_ready,
    input  in_ready, out_valid, gt_cnt, eq_cnt, lt_cnt, err_cnt, major
  );

  // The statistics block itself
  modport slave (
    input  in_valid, gt, eq, lt, out_ready,
    output in_ready, out_valid, gt_cnt, eq_cnt, lt_cnt, err_cnt, major
  );

endinterface

// File: rtl/cmp_stats_cnt.sv
// rtl/cmp_stats_cnt.sv - CW-bit counter with synchronous clear and increment enable
module cmp_stats_cnt #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] q_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear wins over increment; the window bound keeps the count from wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + CW'(1);
  end

  // Count register, asynchronously cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/cmp_stats.sv
// rtl/cmp_stats.sv - windowed gt/eq/lt/error statistics with majority verdict
module cmp_stats
  import cmp_stats_pkg::*;
#(
  parameter int WINDOW = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  cmp_stats_if.slave  bus
);

  localparam int CW = $clog2(WINDOW + 1);

  state_e        state_q, state_d;
  maj_e          major_q, major_d;
  logic [CW-1:0] samp_q;
  logic [CW-1:0] gt_q, eq_q, lt_q, err_q;
  logic [CW-1:0] gt_nxt, eq_nxt, lt_nxt;
  logic          legal, in_fire, out_fire, last;
  logic          gt_inc, eq_inc, lt_inc, err_inc;

  // Handshakes depend only on the registered state, never on in_valid/out_ready paths
  assign in_fire  = bus.in_valid  && (state_q == ST_ACCUM);
  assign out_fire = bus.out_ready && (state_q == ST_REPORT);
  assign last     = in_fire && (samp_q == CW'(WINDOW - 1));

  assign legal   = is_onehot3({bus.gt, bus.eq, bus.lt});
  assign gt_inc  = in_fire &&  legal && bus.gt;
  assign eq_inc  = in_fire &&  legal && bus.eq;
  assign lt_inc  = in_fire &&  legal && bus.lt;
  assign err_inc = in_fire && !legal;

  // Post-edge counts so the verdict includes the sample that closes the window
  assign gt_nxt = gt_q + CW'(gt_inc);
  assign eq_nxt = eq_q + CW'(eq_inc);
  assign lt_nxt = lt_q + CW'(lt_inc);

  cmp_stats_cnt #(.CW(CW)) u_samp (.clk(clk), .rst_n(rst_n), .clr_i(out_fire), .inc_i(in_fire), .q_o(samp_q));
  cmp_stats_cnt #(.CW(CW)) u_gt   (.clk(clk), .rst_n(rst_n), .clr_i(out_fire), .inc_i(gt_inc),  .q_o(gt_q));
  cmp_stats_cnt #(.CW(CW)) u_eq   (.clk(clk), .rst_n(rst_n), .clr_i(out_fire), .inc_i(eq_inc),  .q_o(eq_q));
  cmp_stats_cnt #(.CW(CW)) u_lt   (.clk(clk), .rst_n(rst_n), .clr_i(out_fire), .inc_i(lt_inc),  .q_o(lt_q));
  cmp_stats_cnt #(.CW(CW)) u_err  (.clk(clk), .rst_n(rst_n), .clr_i(out_fire), .inc_i(err_inc), .q_o(err_q));

  // Next state and verdict: latch the verdict on the closing sample, drop it on summary accept
  always_comb begin
    state_d = state_q;
    major_d = major_q;
    case (state_q)
      ST_ACCUM: begin
        if (last) begin
          state_d = ST_REPORT;
          major_d = pick_major(STAT_W'(gt_nxt), STAT_W'(eq_nxt), STAT_W'(lt_nxt));
        end
      end
      ST_REPORT: begin
        if (bus.out_ready) begin
          state_d = ST_ACCUM;
          major_d = MAJ_NONE;
        end
      end
      default: begin
        state_d = ST_ACCUM;
        major_d = MAJ_NONE;
      end
    endcase
  end

  // State and verdict registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      major_q <= MAJ_NONE;
    end else begin
      state_q <= state_d;
      major_q <= major_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.out_valid = (state_q == ST_REPORT);
  assign bus.gt_cnt    = gt_q;
  assign bus.eq_cnt    = eq_q;
  assign bus.lt_cnt    = lt_q;
  assign bus.err_cnt   = err_q;
  assign bus.major     = major_q;

endmodule

// File: tb/tb_cmp_stats.sv
// tb/tb_cmp_stats.sv - directed self-checking bench for cmp_stats
module tb_cmp_stats;
  import cmp_stats_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  cmp_stats_if #(.WINDOW(4))  if4 ();
  cmp_stats_if #(.WINDOW(16)) if16 ();

  cmp_stats #(.WINDOW(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  cmp_stats #(.WINDOW(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  // {gt_cnt, eq_cnt, lt_cnt, err_cnt, major}
  logic [13:0] st4;
  logic [21:0] st16;
  assign st4  = {if4.gt_cnt, if4.eq_cnt, if4.lt_cnt, if4.err_cnt, if4.major};
  assign st16 = {if16.gt_cnt, if16.eq_cnt, if16.lt_cnt, if16.err_cnt, if16.major};

  task automatic push4(input logic [2:0] v);
    int n = 0;
    if4.in_valid = 1'b1;
    {if4.gt, if4.eq, if4.lt} = v;
    while (!if4.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (if4.in_ready !== 1'b1) begin
      bad++; $display("FAIL push4_ready got=%b want=1", if4.in_ready);
    end
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
  endtask

  task automatic push16(input logic [2:0] v);
    int n = 0;
    if16.in_valid = 1'b1;
    {if16.gt, if16.eq, if16.lt} = v;
    while (!if16.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (if16.in_ready !== 1'b1) begin
      bad++; $display("FAIL push16_ready got=%b want=1", if16.in_ready);
    end
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (if4.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready4 got=%b want=1", if4.in_ready); end
    total++; if (if4.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid4 got=%b want=0", if4.out_valid); end
    total++; if (st4 !== 14'h0) begin bad++; $display("FAIL reset_stats4 got=%h want=0", st4); end
    total++; if (if16.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready16 got=%b want=1", if16.in_ready); end
    total++; if (st16 !== 22'h0) begin bad++; $display("FAIL reset_stats16 got=%h want=0", st16); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [13:0] exp;
    if4.out_ready = 1'b1;
    push4(3'b100); push4(3'b100); push4(3'b010); push4(3'b001);
    exp = {3'd2, 3'd1, 3'd1, 3'd0, MAJ_GT};
    total++; if (if4.out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid got=%b want=1", if4.out_valid); end
    total++; if (if4.in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready got=%b want=0", if4.in_ready); end
    total++; if (st4 !== exp) begin bad++; $display("FAIL basic_stats got=%h want=%h", st4, exp); end
    @(posedge clk); #1;
    total++; if (if4.out_valid !== 1'b0) begin bad++; $display("FAIL basic_one_cycle got=%b want=0", if4.out_valid); end
    total++; if (if4.in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_back got=%b want=1", if4.in_ready); end
    total++; if (st4 !== 14'h0) begin bad++; $display("FAIL basic_cleared got=%h want=0", st4); end
  endtask

  task automatic test_tie_and_err();
    logic [13:0] exp;
    if4.out_ready = 1'b1;
    push4(3'b010); push4(3'b010); push4(3'b100); push4(3'b100);
    exp = {3'd2, 3'd2, 3'd0, 3'd0, MAJ_EQ};
    total++; if (st4 !== exp) begin bad++; $display("FAIL tie_stats got=%h want=%h", st4, exp); end
    @(posedge clk); #1;
    push4(3'b000); push4(3'b110); push4(3'b111); push4(3'b000);
    exp = {3'd0, 3'd0, 3'd0, 3'd4, MAJ_NONE};
    total++; if (if4.out_valid !== 1'b1) begin bad++; $display("FAIL err_out_valid got=%b want=1", if4.out_valid); end
    total++; if (st4 !== exp) begin bad++; $display("FAIL err_stats got=%h want=%h", st4, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_all_pairs();
    logic [21:0] exp;
    if16.out_ready = 1'b1;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        push16({a > b, a == b, a < b});
      end
    end
    exp = {5'd6, 5'd4, 5'd6, 5'd0, MAJ_GT};
    total++; if (if16.out_valid !== 1'b1) begin bad++; $display("FAIL pairs_out_valid got=%b want=1", if16.out_valid); end
    total++; if (st16 !== exp) begin bad++; $display("FAIL pairs_stats got=%h want=%h", st16, exp); end
    @(posedge clk); #1;
    total++; if (if16.out_valid !== 1'b0) begin bad++; $display("FAIL pairs_accept got=%b want=0", if16.out_valid); end
  endtask

  task automatic test_back_pressure();
    logic [13:0] exp;
    if4.out_ready = 1'b0;
    push4(3'b001); push4(3'b001); push4(3'b100); push4(3'b010);
    exp = {3'd1, 3'd1, 3'd2, 3'd0, MAJ_LT};
    if4.in_valid = 1'b1;
    {if4.gt, if4.eq, if4.lt} = 3'b100;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++; if (if4.in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready c%0d got=%b want=0", i, if4.in_ready); end
      total++; if (if4.out_valid !== 1'b1) begin bad++; $display("FAIL hold_out_valid c%0d got=%b want=1", i, if4.out_valid); end
      total++; if (st4 !== exp) begin bad++; $display("FAIL hold_stats c%0d got=%h want=%h", i, st4, exp); end
    end
    if4.out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (if4.out_valid !== 1'b0) begin bad++; $display("FAIL bp_accept got=%b want=0", if4.out_valid); end
    total++; if (st4 !== 14'h0) begin bad++; $display("FAIL bp_cleared got=%h want=0", st4); end
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    exp = {3'd1, 3'd0, 3'd0, 3'd0, MAJ_NONE};
    total++; if (st4 !== exp) begin bad++; $display("FAIL bp_held_sample got=%h want=%h", st4, exp); end
    push4(3'b100); push4(3'b100); push4(3'b100);
    exp = {3'd4, 3'd0, 3'd0, 3'd0, MAJ_GT};
    total++; if (if4.out_valid !== 1'b1) begin bad++; $display("FAIL bp_next_valid got=%b want=1", if4.out_valid); end
    total++; if (st4 !== exp) begin bad++; $display("FAIL bp_next_stats got=%h want=%h", st4, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    logic [13:0] exp;
    if4.out_ready = 1'b1;
    push4(3'b100); push4(3'b010);
    #2 rst_n = 1'b0;
    #1;
    total++; if (st4 !== 14'h0) begin bad++; $display("FAIL rst_mid_stats got=%h want=0", st4); end
    total++; if (if4.in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready got=%b want=1", if4.in_ready); end
    #1 rst_n = 1'b1;
    if4.out_ready = 1'b0;
    push4(3'b001); push4(3'b001); push4(3'b001); push4(3'b100);
    exp = {3'd1, 3'd0, 3'd3, 3'd0, MAJ_LT};
    total++; if (if4.out_valid !== 1'b1) begin bad++; $display("FAIL rst_post_valid got=%b want=1", if4.out_valid); end
    total++; if (st4 !== exp) begin bad++; $display("FAIL rst_post_stats got=%h want=%h", st4, exp); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (if4.out_valid !== 1'b0) begin bad++; $display("FAIL rst_rep_out_valid got=%b want=0", if4.out_valid); end
    total++; if (if4.in_ready !== 1'b1) begin bad++; $display("FAIL rst_rep_in_ready got=%b want=1", if4.in_ready); end
    total++; if (st4 !== 14'h0) begin bad++; $display("FAIL rst_rep_stats got=%h want=0", st4); end
    #1 rst_n = 1'b1;
    if4.out_ready = 1'b1;
    push4(3'b010); push4(3'b010); push4(3'b010); push4(3'b010);
    exp = {3'd0, 3'd4, 3'd0, 3'd0, MAJ_EQ};
    total++; if (st4 !== exp) begin bad++; $display("FAIL rst_next_stats got=%h want=%h", st4, exp); end
    @(posedge clk); #1;
    total++; if (if4.out_valid !== 1'b0) begin bad++; $display("FAIL rst_next_accept got=%b want=0", if4.out_valid); end
  endtask

  initial begin
    if4.in_valid = 1'b0;  if4.gt = 1'b0;  if4.eq = 1'b0;  if4.lt = 1'b0;  if4.out_ready = 1'b1;
    if16.in_valid = 1'b0; if16.gt = 1'b0; if16.eq = 1'b0; if16.lt = 1'b0; if16.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_tie_and_err();
    test_all_pairs();
    test_back_pressure();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
